// File: rtl/counter_snapshot_reader_if.sv
// Narrow read-out bus of the counter snapshot reader.
//   Data  : current beat (DATA_W bits)
//   Valid : Data holds a valid beat
//   Ready : consumer accepts the beat when Valid and Ready are both high at a rising edge
//   Last  : high together with Valid on the final beat of a snapshot
// The master modport is the reader side; the slave modport is the consumer side.
interface counter_snapshot_reader_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] Data;
  logic              Valid;
  logic              Ready;
  logic              Last;

  modport master (output Data, output Valid, output Last, input Ready);
  modport slave  (input Data, input Valid, input Last, output Ready);
endinterface

// File: rtl/counter_snapshot_reader.sv
// Counter snapshot reader.
// On Req, both 64-bit counters are captured in the same cycle. The 128-bit
// snapshot is then streamed as 128/DATA_W beats over a valid/ready bus,
// Count0 first and least-significant chunk first, so that a narrow consumer
// sees a tear-free copy of both counters.
// Ports:
//   Clk, Reset     : clock and synchronous active-high reset
//   Count0, Count1 : live counter values, sampled only on capture
//   Req            : snapshot request, honoured only while idle
//   ClrOvf         : clears the sticky Overrun flag (a dropped Req at the same edge wins)
//   Bus            : Data/Valid/Ready/Last beat stream (master side)
//   Busy           : a snapshot is held or being sent
//   Done           : one-cycle pulse after the final beat is accepted
//   Overrun        : sticky, set when a Req arrives while a snapshot is in flight
module counter_snapshot_reader #(
  parameter int DATA_W = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [63:0]                Count0,
  input  logic [63:0]                Count1,
  input  logic                       Req,
  input  logic                       ClrOvf,
  counter_snapshot_reader_if.master  Bus,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Overrun
);

  localparam int BEATS = 128 / DATA_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [127:0]      snap;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic [6:0]        off;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] chunk_next;
  logic              valid;
  logic              capture;
  logic              advance;
  logic              finish;
  logic              dropped;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    dropped = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          capture = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        // Any request while a snapshot is in flight is lost, including
        // one coinciding with the final handshake.
        dropped = Req;
        if (Bus.Ready) begin
          if (idx == LAST_IDX) begin
            finish  = 1'b1;
            state_n = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Data is registered: the next chunk is pre-selected from the snapshot so
  // that an accepted beat is followed by the next one without a bubble.
  assign idx_inc    = idx + 1'b1;
  assign off        = 7'(idx_inc) * 7'(DATA_W);
  assign chunk_next = DATA_W'(snap >> off);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap    <= '0;
      idx     <= '0;
      data_q  <= '0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Done <= finish;
      if (dropped) begin
        Overrun <= 1'b1;
      end else if (ClrOvf) begin
        Overrun <= 1'b0;
      end
      if (capture) begin
        snap   <= {Count1, Count0};
        idx    <= '0;
        data_q <= Count0[DATA_W-1:0];
      end else if (advance) begin
        idx    <= idx_inc;
        data_q <= chunk_next;
      end
    end
  end

  assign valid     = (state == SEND);
  assign Bus.Valid = valid;
  assign Bus.Data  = data_q;
  assign Bus.Last  = valid && (idx == LAST_IDX);
  assign Busy      = valid;

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// Bench for counter_snapshot_reader: a 16-bit and a 64-bit instance share
// all stimulus. A snapshot/queue-level model predicts every output on every
// cycle, and directed sequences pin hand-computed beat values.
module tb_counter_snapshot_reader;

  logic        Clk = 1'b0;
  logic        Reset, Req, ClrOvf, Ready;
  logic [63:0] Count0, Count1;
  logic        busy16, done16, ovf16, busy64, done64, ovf64;

  counter_snapshot_reader_if #(.DATA_W(16)) bus16 ();
  counter_snapshot_reader_if #(.DATA_W(64)) bus64 ();
  assign bus16.Ready = Ready;
  assign bus64.Ready = Ready;

  counter_snapshot_reader #(.DATA_W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Count0(Count0), .Count1(Count1),
    .Req(Req), .ClrOvf(ClrOvf), .Bus(bus16.master),
    .Busy(busy16), .Done(done16), .Overrun(ovf16));

  counter_snapshot_reader #(.DATA_W(64)) dut64 (
    .Clk(Clk), .Reset(Reset), .Count0(Count0), .Count1(Count1),
    .Req(Req), .ClrOvf(ClrOvf), .Bus(bus64.master),
    .Busy(busy64), .Done(done64), .Overrun(ovf64));

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: each instance holds a 128-bit snapshot and a count of beats
  // already accepted; the visible beat is simply that many chunks in.
  int           dw [2] = '{16, 64};
  logic [127:0] m_snap [2];
  int           m_sent [2];
  bit           m_busy [2];
  bit           m_done [2];
  bit           m_ovf  [2];
  bit           started = 1'b0;

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_snap[i] = '0;
        m_sent[i] = 0;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_busy[i] && Req)
          m_ovf[i] = 1'b1;
        else if (ClrOvf)
          m_ovf[i] = 1'b0;
        if (!m_busy[i]) begin
          if (Req) begin
            m_snap[i] = {Count1, Count0};
            m_sent[i] = 0;
            m_busy[i] = 1'b1;
          end
        end else if (Ready) begin
          m_sent[i] = m_sent[i] + 1;
          if (m_sent[i] == 128 / dw[i]) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
    if (Reset) started = 1'b1;
  end

  logic [63:0] o_data [2];
  logic        o_valid [2], o_last [2], o_busy [2], o_done [2], o_ovf [2];
  assign o_data[0]  = 64'(bus16.Data);
  assign o_data[1]  = bus64.Data;
  assign o_valid[0] = bus16.Valid;
  assign o_valid[1] = bus64.Valid;
  assign o_last[0]  = bus16.Last;
  assign o_last[1]  = bus64.Last;
  assign o_busy[0]  = busy16;
  assign o_busy[1]  = busy64;
  assign o_done[0]  = done16;
  assign o_done[1]  = done64;
  assign o_ovf[0]   = ovf16;
  assign o_ovf[1]   = ovf64;

  always @(negedge Clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [127:0] sh;
        logic [63:0]  mask;
        logic [63:0]  exp_data;
        sh       = m_snap[i] >> (m_sent[i] * dw[i]);
        mask     = (dw[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw[i]) - 64'd1);
        exp_data = sh[63:0] & mask;
        chk($sformatf("model%0d Valid", dw[i]), 64'(o_valid[i]), 64'(m_busy[i]));
        chk($sformatf("model%0d Busy", dw[i]), 64'(o_busy[i]), 64'(m_busy[i]));
        chk($sformatf("model%0d Last", dw[i]), 64'(o_last[i]),
            64'(m_busy[i] && (m_sent[i] == 128 / dw[i] - 1)));
        chk($sformatf("model%0d Done", dw[i]), 64'(o_done[i]), 64'(m_done[i]));
        chk($sformatf("model%0d Overrun", dw[i]), 64'(o_ovf[i]), 64'(m_ovf[i]));
        if (m_busy[i])
          chk($sformatf("model%0d Data", dw[i]), o_data[i], exp_data);
      end
    end
  end

  task automatic adv();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  logic [15:0] e16 [8] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123,
                           16'h0005, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    Reset  = 1'b1;
    Req    = 1'b0;
    ClrOvf = 1'b0;
    Ready  = 1'b0;
    Count0 = 64'h0123_4567_89AB_CDEF;
    Count1 = 64'h5;
    adv(); adv();
    Reset = 1'b0;
    at_neg();
    chk("reset Valid", 64'(bus16.Valid), 64'd0);
    chk("reset Busy", 64'(busy16), 64'd0);
    chk("reset Done", 64'(done16), 64'd0);
    chk("reset Overrun", 64'(ovf16), 64'd0);
    chk("reset Data", 64'(bus16.Data), 64'd0);

    // Basic capture, Ready held high
    Ready = 1'b1;
    Req   = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    chk("basic first Valid", 64'(bus16.Valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("basic beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      chk($sformatf("basic beat%0d Last", k), 64'(bus16.Last), 64'(k == 7));
      adv(); at_neg();
    end
    chk("basic Done", 64'(done16), 64'd1);
    chk("basic Busy after", 64'(busy16), 64'd0);
    adv(); at_neg();
    chk("basic Done one cycle", 64'(done16), 64'd0);

    // Backpressure on the second beat
    Req = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bp beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      if (k == 1) begin
        Ready = 1'b0;
        repeat (3) begin
          adv(); at_neg();
          chk("bp hold Data", 64'(bus16.Data), 64'h89AB);
          chk("bp hold Valid", 64'(bus16.Valid), 64'd1);
        end
        Ready = 1'b1;
      end
      adv(); at_neg();
    end
    chk("bp Done", 64'(done16), 64'd1);
    adv(); at_neg();

    // Atomicity: live counter changes after capture
    Req = 1'b1;
    adv();
    Req    = 1'b0;
    Count0 = 64'hFFFF_FFFF_FFFF_FFFF;
    at_neg();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("atomic beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      adv(); at_neg();
    end
    chk("atomic Done", 64'(done16), 64'd1);
    Count0 = 64'h0123_4567_89AB_CDEF;
    adv(); at_neg();

    // Overrun: Req on beat 3 and on the final handshake, then Req in the Done cycle
    Req = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovr beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      if (k == 2 || k == 7) Req = 1'b1;
      adv();
      Req = 1'b0;
      at_neg();
      if (k == 2) chk("ovr set", 64'(ovf16), 64'd1);
      if (k == 5) chk("ovr held", 64'(ovf16), 64'd1);
    end
    chk("ovr final Done", 64'(done16), 64'd1);
    chk("ovr final Overrun", 64'(ovf16), 64'd1);
    Req    = 1'b1;
    ClrOvf = 1'b1;
    adv();
    Req    = 1'b0;
    ClrOvf = 1'b0;
    at_neg();
    chk("ovr cleared", 64'(ovf16), 64'd0);
    chk("ovr restart Valid", 64'(bus16.Valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovr2 beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      adv(); at_neg();
    end
    chk("ovr2 Done", 64'(done16), 64'd1);
    adv(); at_neg();

    // Reset mid-transfer after four beats, with Overrun set beforehand
    Req = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) Req = 1'b1;
      adv();
      Req = 1'b0;
      at_neg();
    end
    chk("rst pre Overrun", 64'(ovf16), 64'd1);
    chk("rst pre Data", 64'(bus16.Data), 64'h0005);
    Reset = 1'b1;
    adv();
    Reset = 1'b0;
    at_neg();
    chk("rst Valid", 64'(bus16.Valid), 64'd0);
    chk("rst Busy", 64'(busy16), 64'd0);
    chk("rst Overrun", 64'(ovf16), 64'd0);
    chk("rst Done", 64'(done16), 64'd0);
    adv(); at_neg();
    chk("rst no Done", 64'(done16), 64'd0);
    Req = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst2 beat%0d Data", k), 64'(bus16.Data), 64'(e16[k]));
      adv(); at_neg();
    end
    chk("rst2 Done", 64'(done16), 64'd1);
    adv(); at_neg();

    // 64-bit instance: two beats
    Count0 = 64'hA;
    Count1 = 64'hB;
    Req    = 1'b1;
    adv();
    Req = 1'b0;
    at_neg();
    chk("w64 beat0 Data", bus64.Data, 64'hA);
    chk("w64 beat0 Last", 64'(bus64.Last), 64'd0);
    adv(); at_neg();
    chk("w64 beat1 Data", bus64.Data, 64'hB);
    chk("w64 beat1 Last", 64'(bus64.Last), 64'd1);
    adv(); at_neg();
    chk("w64 Done", 64'(done64), 64'd1);
    chk("w64 Valid after", 64'(bus64.Valid), 64'd0);
    repeat (10) adv();
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_snapshot_reader.md
Name: counter_snapshot_reader

Overview:
- Read-side companion to the team's dual 64-bit event counter block.
- On request, atomically captures both 64-bit counter values in the same cycle.
- Streams the captured values out as a sequence of narrow beats over a valid/ready handshake, so a narrow consumer (debug port, trace buffer) can read wide counters without tearing.
- Sits between the counter block outputs and the narrow consumer.

Parameters:
- DATA_W, 16, beat width in bits. Legal values: 8, 16, 32, 64; 64 must be divisible by DATA_W.
- BEATS, 2*64/DATA_W (derived, not overridable), number of beats per snapshot.

Ports:
- Clk  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Count0  input  64  first counter value to capture.
- Count1  input  64  second counter value to capture.
- Req  input  1  snapshot request; sampled on each rising edge.
- ClrOvf  input  1  clears the sticky Overrun flag.
- Data  output  DATA_W  current beat.
- Valid  output  1  Data holds a valid beat.
- Ready  input  1  consumer accepts the beat when Valid and Ready are both high at a rising edge.
- Last  output  1  high together with Valid on the final beat.
- Busy  output  1  high while a snapshot is held or being sent.
- Done  output  1  one-cycle pulse after the final beat is accepted.
- Overrun  output  1  sticky flag: a request was dropped.

Behaviour:
- Reset (when Reset is high at a rising edge): state IDLE, Valid=0, Last=0, Busy=0, Done=0, Overrun=0, Data=0, beat index=0, snapshot registers=0. Reset overrides every other input, including in the middle of a transfer; the partial transfer is discarded and no Done pulse is produced.
- States: IDLE and SEND.
- IDLE to SEND: on an edge where Req=1.
  - At that edge, snapshot = {Count1, Count0} (128 bits), beat index = 0.
  - From the next cycle: Valid=1, Busy=1. Latency from Req to the first Valid is 1 cycle.
- Beat order: Count0 first, least-significant chunk first; then Count1, least-significant chunk first.
  - Beat k carries snapshot bits [k*DATA_W +: DATA_W].
- Data is driven from a register and holds stable while Valid=1 and Ready=0. Valid never drops before its beat is accepted.
- Accepted beat (Valid and Ready both high at an edge): beat index increments and Data advances to the next chunk on the next cycle. There are no bubbles when Ready stays high, so one beat is transferred per cycle.
- Last = Valid and (beat index == BEATS-1).
- Final beat accepted: next cycle state=IDLE, Valid=0, Busy=0, Last=0, Done=1 for exactly one cycle.
- Req while in SEND, including the cycle in which the final beat is accepted: the request is ignored and Overrun is set to 1.
  - A new Req is honoured only when state==IDLE, so the earliest back-to-back capture is in the cycle Done is high.
- Overrun clears on ClrOvf=1. If ClrOvf and a dropped Req occur at the same edge, set wins (Overrun=1).
- The live Count0/Count1 inputs are ignored after capture; changes during SEND do not affect the beats.
- Ready while Valid=0 has no effect.
- The beat index wraps by returning to 0 on capture; it never counts past BEATS-1.

Test Plan:
- Basic capture, DATA_W=16, Count0=64'h0123456789ABCDEF, Count1=64'h5, Req for 1 cycle, Ready held high -> Valid high 1 cycle after Req; 8 consecutive beats CDEF, 89AB, 4567, 0123, 0005, 0000, 0000, 0000; Last only on beat 8; Done pulses the cycle after; Busy low.
- Backpressure: same values, Ready=0 for 3 cycles on beat 2 -> Data stays 89AB and Valid stays 1 for those cycles; stream resumes with 4567; total beats = 8, none duplicated or skipped.
- Atomicity: change Count0 to 64'hFFFF... one cycle after Req -> every beat still matches the values captured at the Req edge.
- Overrun: Req during beat 3, and Req in the final-handshake cycle -> both ignored, Overrun=1 and held; ClrOvf=1 -> Overrun=0 next cycle; a Req in the Done cycle starts a new snapshot.
- Reset mid-transfer after beat 4 -> next cycle Valid=0, Busy=0, Overrun=0, no Done pulse; a following Req yields a fresh 8-beat snapshot starting from beat 0.
- DATA_W=64: Count0=64'hA, Count1=64'hB -> exactly 2 beats, 64'hA then 64'hB with Last; Done follows.
